// File: rtl/sram_controller_if.sv
// CPU-side word access bus between the MEM stage and the SRAM controller.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
    modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit CPU access into two halfword accesses on an external
// 16-bit asynchronous SRAM, holding each phase for WAIT_CYCLES cycles.
module sram_controller #(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);
    localparam int IDX_W = SRAM_AW - 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [31:0]      BASE       = 32'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [15:0]        lo_q, lo_d;
    logic [31:0]        read_data_q, read_data_d;
    logic               req;

    assign req           = bus.wr_en | bus.rd_en;
    assign bus.ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign bus.read_data = read_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            read_data_q <= read_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = CNT_RELOAD;
                    we_d    = bus.wr_en;
                    idx_d   = IDX_W'((bus.address - BASE) >> 2);
                    wdata_d = bus.write_data;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = CNT_RELOAD;
                    if (!we_q) lo_d = sram_dq_in;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HIGH: begin
                // High halfword goes straight into read_data so it is valid from the start of DONE.
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!we_q) read_data_d = {sram_dq_in, lo_q};
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM pins come only from state and latched registers, never from the live request.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (state_q == LOW || state_q == HIGH) begin
            sram_addr = {idx_q, (state_q == HIGH)};
            if (we_q) begin
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
                sram_dq_out = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
            end
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: cycle traces, a vector table and random traffic
// checked against a word-level memory model.
module tb_sram_controller;
    localparam int W0 = 2;
    localparam int W1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_controller_if bif0 ();
    sram_controller_if bif1 ();

    logic [17:0] sram_addr0, sram_addr1;
    logic [15:0] dq_out0, dq_out1, dq_in0, dq_in1;
    logic        oe0, oe1, we_n0, we_n1;

    logic [15:0] mem0 [0:1023];
    logic [15:0] mem1 [0:1023];

    assign dq_in0 = mem0[sram_addr0[9:0]];
    assign dq_in1 = mem1[sram_addr1[9:0]];
    always @(posedge clk) if (!we_n0) mem0[sram_addr0[9:0]] <= dq_out0;
    always @(posedge clk) if (!we_n1) mem1[sram_addr1[9:0]] <= dq_out1;

    sram_controller #(.WAIT_CYCLES(W0), .BASE_ADDR(1024), .SRAM_AW(18)) u0 (
        .clk(clk), .rst(rst), .bus(bif0.slave),
        .sram_addr(sram_addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
        .sram_dq_oe(oe0), .sram_we_n(we_n0));

    sram_controller #(.WAIT_CYCLES(W1), .BASE_ADDR(1024), .SRAM_AW(18)) u1 (
        .clk(clk), .rst(rst), .bus(bif1.slave),
        .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
        .sram_dq_oe(oe1), .sram_we_n(we_n1));

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = 32'h0;

    typedef struct {
        logic        we;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word index the spec's address rule maps a CPU byte address onto.
    function automatic int wkey(input logic [31:0] a);
        return int'(((a - 32'd1024) >> 2) & 32'h1FFFF);
    endfunction

    // Called at #1 after a posedge with the controller idle; returns likewise.
    task automatic access(input logic we, input logic rd, input logic [31:0] a, input logic [31:0] d);
        int n;
        logic bad;
        logic [31:0] exp;
        bif0.wr_en = we; bif0.rd_en = rd; bif0.address = a; bif0.write_data = d;
        n = 0; bad = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            if (bif0.ready) break;
            if (!we && (oe0 || !we_n0)) bad = 1'b1;
            n++;
        end
        chk("latency", 32'(n), 32'(2 * W0 + 1));
        if (we) begin
            ref_mem[wkey(a)] = d;
            chk("rd_hold_on_write", bif0.read_data, last_rd);
        end else begin
            exp = ref_mem[wkey(a)];
            chk("read_data", bif0.read_data, exp);
            chk("read_bus_quiet", 32'(bad), 32'h0);
            last_rd = exp;
        end
        @(posedge clk); #1;
        bif0.wr_en = 1'b0; bif0.rd_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [8];
        logic [31:0] a;
        int n;

        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'd1, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'd2, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'd1032, 32'd3, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'd1025, 32'h0, 32'd1};
        vecs[4] = '{1'b0, 1'b1, 32'd1030, 32'h0, 32'd2};
        vecs[5] = '{1'b0, 1'b1, 32'd1035, 32'h0, 32'd3};
        vecs[6] = '{1'b1, 1'b1, 32'd1028, 32'hA5A5_5A5A, 32'd3};
        vecs[7] = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'hA5A5_5A5A};

        bif0.wr_en = 0; bif0.rd_en = 0; bif0.address = 0; bif0.write_data = 0;
        bif1.wr_en = 0; bif1.rd_en = 0; bif1.address = 0; bif1.write_data = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_read_data", bif0.read_data, 32'h0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready_wen_oe", {29'h0, bif0.ready, we_n0, oe0}, 32'h6);
        end
        @(posedge clk); #1;

        // W=2 write trace
        bif0.wr_en = 1; bif0.address = 32'd1024; bif0.write_data = 32'h1234_5678;
        @(negedge clk);
        chk("wr_c0_ready", 32'(bif0.ready), 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("wr_trace_we_n", 32'(we_n0), (c == 5) ? 32'h1 : 32'h0);
            chk("wr_trace_ready", 32'(bif0.ready), (c == 5) ? 32'h1 : 32'h0);
            chk("wr_trace_addr", 32'(sram_addr0), (c == 3 || c == 4) ? 32'h1 : 32'h0);
            chk("wr_trace_dq", 32'(dq_out0), (c <= 2) ? 32'h5678 : (c <= 4) ? 32'h1234 : 32'h0);
        end
        ref_mem[0] = 32'h1234_5678;
        @(posedge clk); #1;
        bif0.wr_en = 0;

        for (int i = 0; i < 8; i++) begin
            access(vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].data);
            chk("vec_read_data", bif0.read_data, vecs[i].exp_rd);
        end

        // W=1: write then traced read of word 1
        bif1.wr_en = 1; bif1.address = 32'd1028; bif1.write_data = 32'hCAFE_BABE;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bif1.ready) break;
            n++;
        end
        chk("w1_write_latency", 32'(n), 32'd3);
        @(posedge clk); #1;
        bif1.wr_en = 0; bif1.rd_en = 1;
        @(negedge clk);
        chk("w1_c0_ready", 32'(bif1.ready), 32'h0);
        @(negedge clk);
        chk("w1_c1_addr", 32'(sram_addr1), 32'd2);
        chk("w1_c1_ready", 32'(bif1.ready), 32'h0);
        @(negedge clk);
        chk("w1_c2_addr", 32'(sram_addr1), 32'd3);
        chk("w1_c2_ready", 32'(bif1.ready), 32'h0);
        @(negedge clk);
        chk("w1_c3_ready", 32'(bif1.ready), 32'h1);
        chk("w1_read_data", bif1.read_data, 32'hCAFE_BABE);
        @(posedge clk); #1;
        bif1.rd_en = 0;

        // reset during cycle 2 of a write
        bif0.wr_en = 1; bif0.address = 32'd1040; bif0.write_data = 32'hDEAD_BEEF;
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_we_n", 32'(we_n0), 32'h1);
        chk("rst_oe", 32'(oe0), 32'h0);
        chk("rst_addr", 32'(sram_addr0), 32'h0);
        chk("rst_ready_req", 32'(bif0.ready), 32'h0);
        bif0.wr_en = 0;
        #1;
        chk("rst_ready_noreq", 32'(bif0.ready), 32'h1);
        chk("rst_read_data", bif0.read_data, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        ref_mem.delete(wkey(32'd1040));
        last_rd = 32'h0;
        access(1'b0, 1'b1, 32'd1032, 32'h0);

        // random traffic, including aliased addresses past the SRAM size
        for (int i = 0; i < 40; i++) begin
            a = 32'd1024 + (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a + 32'h0008_0000;
            if (!ref_mem.exists(wkey(a)) || $urandom_range(0, 1) == 1)
                access(1'b1, 1'($urandom_range(0, 1)), a, $urandom);
            else
                access(1'b0, 1'b1, a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
